freelist_ckpt: RTL and testbench
================================

# freelist_ckpt

Multi-lane physical-register free list with branch checkpoint/restore; parametrised successor to the single-lane `freelist` banks. Feeds the rename stage up to LANES new physical destinations per cycle and accepts up to LANES released registers per cycle from commit. Snapshots the allocation head per in-flight branch and restores it in one cycle on a branch kill, so mispredict recovery needs no walk of the ROB.

## Interface
- WIDTH, 7: physical register number width (WIDTH_PRD)
- SIZE, 32: entries; power of two, ≥ LANES
- STNUM, 1: first register number loaded at reset
- LANES, 4: allocate and free lanes
- NCKPT, 3: checkpoint slots (WIDTH_BRM)
- i_clk  in  1  clock; one clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_re  in  LANES  allocate request per lane
- o_data  out  LANES*WIDTH  granted register per lane, lane k at [(k+1)*WIDTH-1:k*WIDTH]
- o_stall  out  1  requests exceed free count; nothing granted
- o_count  out  log2(SIZE)+1  current free entries
- i_we  in  LANES  free-write enable per lane
- i_data  in  LANES*WIDTH  registers being freed
- i_ckpt_en  in  1  take snapshot
- i_ckpt_id  in  NCKPT  one-hot snapshot slot
- i_kill_en  in  1  restore from snapshot
- i_kill_id  in  NCKPT  one-hot snapshot slot
- o_err  out  1  sticky: overflow or kill of an invalid slot

## Operation
- Storage: circular RAM `mem[SIZE]`; head/tail pointers with one extra wrap bit (D = log2(SIZE) + 1 bits each); count = tail − head mod 2^D.
- Reset: mem[i] = STNUM + i; head = 0; tail = SIZE (wrap bit 1, index 0); count = SIZE; snapshot valid bits cleared; o_err = 0.
- Allocate: n = popcount(i_re).
  - If n ≤ count: lane k with i_re[k] gets mem[head + popcount(i_re[k-1:0])], and head += n.
  - Lanes with i_re[k] = 0 output don't-care (drive 0).
  - If n > count: o_stall = 1, head unchanged, all outputs 0. No partial grant.
- Free: lane k with i_we[k] writes i_data lane k to mem[tail + popcount(i_we[k-1:0])]; tail += popcount(i_we).
  - If count − n_alloc + n_free > SIZE: the whole free is dropped and o_err is set.
- Checkpoint: on i_ckpt_en, slot i_ckpt_id stores the post-allocation head of the same cycle and sets its valid bit.
- Kill: on i_kill_en with a valid slot, head = snapshot and that slot's valid bit clears. Other slots are untouched; the branch unit issues separate kills for younger branches.
  - Kill of an invalid slot: no-op and o_err set.
- Simultaneous events:
  - Kill + allocate: kill wins, allocation ignored, o_stall = 0.
  - Kill + checkpoint: checkpoint ignored.
  - Kill + free: free still applied, since tail is independent of head.
  - Allocate + free: count check uses the pre-cycle count, so a register freed this cycle is not allocatable this cycle.
  - Non-one-hot ckpt or kill id: lowest set bit used.

## Timing
- o_data and o_stall are combinational from state and i_re (same-cycle grant); o_count is from state only.
- Pointers, mem, snapshots and o_err update on the rising edge of i_clk.
- A freed register is allocatable from the next cycle. A restored head is visible on o_data the cycle after the kill.
- Reset is asynchronous: asserting i_rst_n low mid-operation immediately returns all state to reset values. Outputs after reset: o_stall = 0, o_count = SIZE, o_err = 0, o_data = 0 until requested.
- Pointer wrap: the index uses the low log2(SIZE) bits; the wrap bit distinguishes full from empty (head == tail means empty).

## Structure
- Shared package `core_pkg`: WIDTH_PRD, WIDTH_BRM, the pointer-width function clog2, and the ckpt slot struct {valid, head}.
- One sub-module `prefix_count`: LANES-bit mask in, exclusive prefix popcount per lane plus total out. Instantiated twice, once for i_re and once for i_we.

## Test plan
- Reset with STNUM=1, SIZE=32, i_re=4'b1111 → o_data lanes {4,3,2,1}; next cycle o_count=28, lane 0 = 5.
- i_re=4'b1010 from reset → lane1=1, lane3=2; next cycle i_re=4'b0001 gives 3.
- Drain to count=2, then i_re=4'b0111 → o_stall=1, head unchanged. Same cycle i_we=4'b0001 with data 40 → next cycle count=3 and the request is granted.
- Checkpoint slot 3'b010 at head=8, allocate 12, then kill slot 3'b010 → next cycle lane 0 = 9, o_count restored. Kill slot 3'b010 again → o_err=1.
- Kill and i_re=4'b1111 in the same cycle → no allocation; head = snapshot. A concurrent i_we=4'b0011 still advances tail by 2.
- Free 4 registers while full → dropped, o_err=1; assert i_rst_n=0 mid-test → o_err=0 and o_count=32 with no clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared rename-stage definitions: register/branch-mask widths, the pointer
// width helper and the branch checkpoint slot record.
package core_pkg;

  localparam int WIDTH_PRD = 7;
  localparam int WIDTH_BRM = 3;

  // Snapshot heads are stored at a fixed generous width so the slot record
  // does not depend on the free-list depth; users take the low bits they need.
  localparam int PTR_MAX_W = 16;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [PTR_MAX_W-1:0] head;
  } ckpt_t;

endpackage

// File: rtl/prefix_count.sv
// Exclusive prefix popcount of a lane mask: lane k gets the number of set
// bits below it, plus the total number of set bits.
module prefix_count
  import core_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CW    = clog2(LANES) + 1
) (
  input  logic [LANES-1:0]    mask,
  output logic [LANES*CW-1:0] prefix,
  output logic [CW-1:0]       total
);

  // Running sum across lanes; each lane sees the sum before adding itself.
  always_comb begin
    total  = '0;
    prefix = '0;
    for (int k = 0; k < LANES; k++) begin
      prefix[k*CW +: CW] = total;
      total = total + CW'(mask[k]);
    end
  end

endmodule

// File: rtl/freelist_ckpt.sv
// Multi-lane physical register free list with per-branch head checkpoints.
// Allocation pops from head, commit frees push at tail, and a branch kill
// restores head from its snapshot in a single cycle.
//
// Request/grant: i_re is a per-lane request. The request set is granted as a
// whole in the same cycle (o_data valid, o_stall low) when enough entries are
// free, otherwise nothing is granted and o_stall is high; the requester holds
// or re-issues the request. A valid kill suppresses allocation and checkpoint.
module freelist_ckpt
  import core_pkg::*;
#(
  parameter int WIDTH = WIDTH_PRD,
  parameter int SIZE  = 32,
  parameter int STNUM = 1,
  parameter int LANES = 4,
  parameter int NCKPT = WIDTH_BRM
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [LANES-1:0]       i_re,
  output logic [LANES*WIDTH-1:0] o_data,
  output logic                   o_stall,
  output logic [clog2(SIZE):0]   o_count,
  input  logic [LANES-1:0]       i_we,
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic                   i_ckpt_en,
  input  logic [NCKPT-1:0]       i_ckpt_id,
  input  logic                   i_kill_en,
  input  logic [NCKPT-1:0]       i_kill_id,
  output logic                   o_err
);

  localparam int AW = clog2(SIZE);
  localparam int D  = AW + 1;
  localparam int D1 = D + 1;
  localparam int CW = clog2(LANES) + 1;

  logic [WIDTH-1:0]    mem [SIZE];
  logic [D-1:0]        head;
  logic [D-1:0]        tail;
  logic                err;
  ckpt_t               snap [NCKPT];

  logic [D-1:0]        count;
  logic [LANES*CW-1:0] re_pre;
  logic [CW-1:0]       re_total;
  logic [LANES*CW-1:0] we_pre;
  logic [CW-1:0]       we_total;
  logic [D-1:0]        rd_ptr [LANES];
  logic [D-1:0]        wr_ptr [LANES];
  logic                kill_hit;
  logic                kill_bad;
  logic [D-1:0]        kill_head;
  logic [NCKPT-1:0]    kill_sel;
  logic [NCKPT-1:0]    ckpt_sel;
  logic                short_of_regs;
  logic                grant;
  logic [D-1:0]        alloc_n;
  logic [D-1:0]        post_head;
  logic [D1-1:0]       after_free;
  logic                ovf;
  logic                free_ok;

  prefix_count #(.LANES(LANES), .CW(CW)) u_re_count (
    .mask   (i_re),
    .prefix (re_pre),
    .total  (re_total)
  );

  prefix_count #(.LANES(LANES), .CW(CW)) u_we_count (
    .mask   (i_we),
    .prefix (we_pre),
    .total  (we_total)
  );

  // The wrap bit makes tail - head the exact occupancy, including full.
  assign count   = tail - head;
  assign o_count = count;
  assign o_err   = err;

  // Non-one-hot ids resolve to their lowest set bit.
  assign kill_sel = i_kill_id & (~i_kill_id + 1'b1);
  assign ckpt_sel = i_ckpt_id & (~i_ckpt_id + 1'b1);

  // Look up the selected snapshot; a kill only acts on a valid slot.
  always_comb begin
    kill_hit  = 1'b0;
    kill_head = '0;
    for (int i = 0; i < NCKPT; i++) begin
      if (i_kill_en && kill_sel[i] && snap[i].valid) begin
        kill_hit  = 1'b1;
        kill_head = D'(snap[i].head);
      end
    end
  end

  assign kill_bad      = i_kill_en && !kill_hit;
  assign short_of_regs = D'(re_total) > count;
  assign grant         = !kill_hit && !short_of_regs;
  assign o_stall       = !kill_hit && short_of_regs;
  assign alloc_n       = grant ? D'(re_total) : '0;
  assign post_head     = head + alloc_n;

  // Occupancy check uses the pre-cycle count so a register freed this cycle
  // cannot be handed out in the same cycle.
  assign after_free = D1'(count) + D1'(we_total) - D1'(alloc_n);
  assign ovf        = after_free > D1'(SIZE);
  assign free_ok    = (|i_we) && !ovf;

  // Per-lane RAM pointers and the same-cycle grant data.
  always_comb begin
    o_data = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_ptr[k] = head + D'(re_pre[k*CW +: CW]);
      wr_ptr[k] = tail + D'(we_pre[k*CW +: CW]);
      if (grant && i_re[k]) o_data[k*WIDTH +: WIDTH] = mem[rd_ptr[k][AW-1:0]];
    end
  end

  // State update: pointers, free-list RAM, snapshots and the sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= WIDTH'(STNUM + i);
      head <= '0;
      tail <= D'(SIZE);
      err  <= 1'b0;
      for (int i = 0; i < NCKPT; i++) snap[i] <= '0;
    end else begin
      head <= kill_hit ? kill_head : post_head;
      if (free_ok) begin
        for (int k = 0; k < LANES; k++) begin
          if (i_we[k]) mem[wr_ptr[k][AW-1:0]] <= i_data[k*WIDTH +: WIDTH];
        end
        tail <= tail + D'(we_total);
      end
      for (int i = 0; i < NCKPT; i++) begin
        if (kill_hit && kill_sel[i]) begin
          snap[i].valid <= 1'b0;
        end else if (!kill_hit && i_ckpt_en && ckpt_sel[i]) begin
          snap[i].valid <= 1'b1;
          snap[i].head  <= PTR_MAX_W'(post_head);
        end
      end
      if (ovf || kill_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_freelist_ckpt.sv
// Bench for freelist_ckpt: a cycle table from reset, hand-written corner
// sequences, and randomized traffic against a ring-buffer reference model.
module tb_freelist_ckpt;

  localparam int WIDTH = 7;
  localparam int SIZE  = 32;
  localparam int STNUM = 1;
  localparam int LANES = 4;
  localparam int NCKPT = 3;

  logic                   clk;
  logic                   rst_n;
  logic [LANES-1:0]       re;
  logic [LANES*WIDTH-1:0] data_out;
  logic                   stall;
  logic [5:0]             count;
  logic [LANES-1:0]       we;
  logic [LANES*WIDTH-1:0] data_in;
  logic                   ckpt_en;
  logic [NCKPT-1:0]       ckpt_id;
  logic                   kill_en;
  logic [NCKPT-1:0]       kill_id;
  logic                   err;

  int n_checks = 0;
  int n_fail   = 0;

  freelist_ckpt #(
    .WIDTH(WIDTH), .SIZE(SIZE), .STNUM(STNUM), .LANES(LANES), .NCKPT(NCKPT)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_re      (re),
    .o_data    (data_out),
    .o_stall   (stall),
    .o_count   (count),
    .i_we      (we),
    .i_data    (data_in),
    .i_ckpt_en (ckpt_en),
    .i_ckpt_id (ckpt_id),
    .i_kill_en (kill_en),
    .i_kill_id (kill_id),
    .o_err     (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    re = '0; we = '0; data_in = '0;
    ckpt_en = 1'b0; ckpt_id = '0; kill_en = 1'b0; kill_id = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [27:0] wd,
                       input logic ce, input logic [2:0] cid,
                       input logic ke, input logic [2:0] kid);
    @(negedge clk);
    re = r; we = w; data_in = wd;
    ckpt_en = ce; ckpt_id = cid; kill_en = ke; kill_id = kid;
    #1;
  endtask

  function automatic logic [27:0] pack(input int l3, input int l2, input int l1, input int l0);
    return {7'(l3), 7'(l2), 7'(l1), 7'(l0)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [27:0] ed, input logic es,
                           input logic [5:0] ec, input logic ee);
    check({tag, ".data"},  32'(data_out), 32'(ed));
    check({tag, ".stall"}, 32'(stall),    32'(es));
    check({tag, ".count"}, 32'(count),    32'(ec));
    check({tag, ".err"},   32'(err),      32'(ee));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  re;
    logic [3:0]  we;
    logic [27:0] wdata;
    logic        ckpt_en;
    logic [2:0]  ckpt_id;
    logic        kill_en;
    logic [2:0]  kill_id;
    logic [27:0] exp_data;
    logic        exp_stall;
    logic [5:0]  exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vec [10];

  // ---------------- reference model ----------------
  int         m_head, m_tail;
  logic [6:0] m_mem [SIZE];
  bit         m_valid [NCKPT];
  int         m_snap [NCKPT];
  bit         m_err;

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int pop4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic model_reset();
    m_head = 0;
    m_tail = SIZE;
    for (int i = 0; i < SIZE; i++) m_mem[i] = 7'(STNUM + i);
    for (int i = 0; i < NCKPT; i++) begin m_valid[i] = 0; m_snap[i] = 0; end
    m_err = 0;
  endtask

  task automatic run_random(input int cycles);
    logic [3:0]  r, w;
    logic [27:0] wd, ed;
    logic        ce, ke, kok, es, ovf, grant;
    logic [2:0]  cid, kid;
    int ks, cs, n, nf, cnt, j, after_alloc;
    for (int c = 0; c < cycles; c++) begin
      r   = 4'($urandom_range(0, 15));
      w   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      wd  = 28'($urandom);
      ce  = ($urandom_range(0, 3) == 0);
      cid = 3'($urandom_range(0, 7));
      ke  = ($urandom_range(0, 7) == 0);
      kid = 3'($urandom_range(1, 7));
      nf  = pop4(w);
      ks  = lowest(kid);
      kok = ke && m_valid[ks];
      // A restore must not leave more entries than the list can hold.
      if (kok && (m_tail + nf - m_snap[ks] > SIZE)) begin ke = 1'b0; kok = 1'b0; end
      cnt   = m_tail - m_head;
      n     = pop4(r);
      es    = !kok && (n > cnt);
      grant = !kok && (n <= cnt);
      ed    = '0;
      j     = 0;
      for (int k = 0; k < LANES; k++) begin
        if (r[k] && grant) begin
          ed[k*WIDTH +: WIDTH] = m_mem[(m_head + j) % SIZE];
          j++;
        end
      end
      drive(r, w, wd, ce, cid, ke, kid);
      check_all($sformatf("rand%0d", c), ed, es, 6'(cnt), m_err);
      after_alloc = grant ? m_head + n : m_head;
      ovf = (cnt - (grant ? n : 0) + nf) > SIZE;
      if (!ovf) begin
        j = 0;
        for (int k = 0; k < LANES; k++) begin
          if (w[k]) begin
            m_mem[(m_tail + j) % SIZE] = wd[k*WIDTH +: WIDTH];
            j++;
          end
        end
        m_tail = m_tail + nf;
      end
      cs = lowest(cid);
      if (!kok && ce && cs >= 0) begin m_valid[cs] = 1; m_snap[cs] = after_alloc; end
      if (kok) begin m_head = m_snap[ks]; m_valid[ks] = 0; end
      else m_head = after_alloc;
      if (ovf || (ke && !kok)) m_err = 1;
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    vec[0] = '{re:4'b1111, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:0, kill_id:0,
               exp_data:pack(4, 3, 2, 1), exp_stall:0, exp_count:32, exp_err:0};
    vec[1] = '{re:4'b0001, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:0, kill_id:0,
               exp_data:pack(0, 0, 0, 5), exp_stall:0, exp_count:28, exp_err:0};
    vec[2] = '{re:4'b1010, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:0, kill_id:0,
               exp_data:pack(7, 0, 6, 0), exp_stall:0, exp_count:27, exp_err:0};
    vec[3] = '{re:4'b0000, we:4'b0011, wdata:pack(0, 0, 51, 50), ckpt_en:0, ckpt_id:0, kill_en:0,
               kill_id:0, exp_data:'0, exp_stall:0, exp_count:25, exp_err:0};
    vec[4] = '{re:4'b0000, we:4'b0, wdata:'0, ckpt_en:1, ckpt_id:3'b001, kill_en:0, kill_id:0,
               exp_data:'0, exp_stall:0, exp_count:27, exp_err:0};
    vec[5] = '{re:4'b1111, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:0, kill_id:0,
               exp_data:pack(11, 10, 9, 8), exp_stall:0, exp_count:27, exp_err:0};
    vec[6] = '{re:4'b0001, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:1, kill_id:3'b001,
               exp_data:'0, exp_stall:0, exp_count:23, exp_err:0};
    vec[7] = '{re:4'b0001, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:0, kill_id:0,
               exp_data:pack(0, 0, 0, 8), exp_stall:0, exp_count:27, exp_err:0};
    vec[8] = '{re:4'b0000, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:1, kill_id:3'b001,
               exp_data:'0, exp_stall:0, exp_count:26, exp_err:0};
    vec[9] = '{re:4'b0000, we:4'b0, wdata:'0, ckpt_en:0, ckpt_id:0, kill_en:0, kill_id:0,
               exp_data:'0, exp_stall:0, exp_count:26, exp_err:1};

    do_reset();
    #1;
    check_all("reset", '0, 1'b0, 6'd32, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(vec[i].re, vec[i].we, vec[i].wdata, vec[i].ckpt_en, vec[i].ckpt_id,
            vec[i].kill_en, vec[i].kill_id);
      check_all($sformatf("vec%0d", i), vec[i].exp_data, vec[i].exp_stall,
                vec[i].exp_count, vec[i].exp_err);
    end

    // Drain to two free entries, then an oversized request stalls while a free lands.
    do_reset();
    for (int i = 0; i < 7; i++) drive(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    drive(4'b0011, 4'b0, '0, 0, 0, 0, 0);
    check_all("drain", pack(0, 0, 30, 29), 1'b0, 6'd4, 1'b0);
    drive(4'b0111, 4'b0001, pack(0, 0, 0, 40), 0, 0, 0, 0);
    check_all("stall", '0, 1'b1, 6'd2, 1'b0);
    drive(4'b0111, 4'b0, '0, 0, 0, 0, 0);
    check_all("after_stall", pack(0, 40, 32, 31), 1'b0, 6'd3, 1'b0);
    drive(4'b0000, 4'b0, '0, 0, 0, 0, 0);
    check_all("empty", '0, 1'b0, 6'd0, 1'b0);

    // Checkpoint at head 8, allocate 12, restore, then a repeated kill errors.
    do_reset();
    drive(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    drive(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    drive(4'b0000, 4'b0, '0, 1, 3'b010, 0, 0);
    for (int i = 0; i < 3; i++) drive(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    drive(4'b0000, 4'b0, '0, 0, 0, 1, 3'b010);
    check_all("kill", '0, 1'b0, 6'd12, 1'b0);
    drive(4'b0001, 4'b0, '0, 0, 0, 0, 0);
    check_all("restored", pack(0, 0, 0, 9), 1'b0, 6'd24, 1'b0);
    drive(4'b0000, 4'b0, '0, 0, 0, 1, 3'b010);
    check_all("rekill", '0, 1'b0, 6'd23, 1'b0);
    drive(4'b0000, 4'b0, '0, 0, 0, 0, 0);
    check_all("rekill_err", '0, 1'b0, 6'd23, 1'b1);

    // Snapshot is post-allocation; kill beats allocation but not the free.
    do_reset();
    drive(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    drive(4'b1111, 4'b0, '0, 1, 3'b101, 0, 0);
    drive(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    check_all("pre_kill", pack(12, 11, 10, 9), 1'b0, 6'd24, 1'b0);
    drive(4'b1111, 4'b0011, pack(0, 0, 61, 60), 0, 0, 1, 3'b001);
    check_all("kill_alloc", '0, 1'b0, 6'd20, 1'b0);
    drive(4'b0001, 4'b0, '0, 0, 0, 0, 0);
    check_all("kill_free", pack(0, 0, 0, 9), 1'b0, 6'd26, 1'b0);

    // Free while full is dropped; asynchronous reset clears state off-edge.
    do_reset();
    drive(4'b0000, 4'b1111, pack(73, 72, 71, 70), 0, 0, 0, 0);
    check_all("overfree", '0, 1'b0, 6'd32, 1'b0);
    drive(4'b1111, 4'b0, '0, 0, 0, 0, 0);
    check_all("overfree_err", pack(4, 3, 2, 1), 1'b0, 6'd32, 1'b1);
    drive(4'b0000, 4'b0, '0, 0, 0, 0, 0);
    check_all("pre_async", '0, 1'b0, 6'd28, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", '0, 1'b0, 6'd32, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    run_random(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
